// File: rtl/n4_c2_neg_stage_pkg.sv
// n4_c2_neg_stage_pkg: shared operand width, counter default, result record and buffer occupancy encodings
package n4_c2_neg_stage_pkg;
    localparam int OP_W        = 4;
    localparam int OWCNT_W_DEF = 4;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } occ_t;
    typedef struct packed {
        logic [OP_W-1:0] z;
        logic            ow;
    } res_t;
endpackage

// File: rtl/n4_c2_neg_stage_if.sv
// n4_c2_neg_stage_if: operand-in and result-out valid/ready channels of the negate stage
//   x3_x0/in_valid/in_ready   : operand stream into the stage
//   z3_z0/ow/out_valid/out_ready : result stream out of the stage
//   master = producer/consumer side, slave = the stage itself
interface n4_c2_neg_stage_if;
    import n4_c2_neg_stage_pkg::*;
    logic [OP_W-1:0] x3_x0;
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] z3_z0;
    logic            ow;
    logic            out_valid;
    logic            out_ready;
    modport master (output x3_x0, in_valid, out_ready, input in_ready, z3_z0, ow, out_valid);
    modport slave  (input x3_x0, in_valid, out_ready, output in_ready, z3_z0, ow, out_valid);
endinterface

// File: rtl/n4_c2_neg_stage_negator.sv
// n4_c2_negator: combinational 4-digit two's-complement negator
//   x3_x0 : operand
//   z3_z0 : (~x3_x0 + 1) mod 16
//   ow    : overflow, set only when the operand is the most negative value
module n4_c2_negator
    import n4_c2_neg_stage_pkg::*;
(
    input  logic [OP_W-1:0] x3_x0,
    output logic [OP_W-1:0] z3_z0,
    output logic            ow
);
    assign z3_z0 = ~x3_x0 + OP_W'(1);
    assign ow    = x3_x0[OP_W-1] & z3_z0[OP_W-1];
endmodule

// File: rtl/n4_c2_neg_stage.sv
// n4_c2_neg_stage: registered, handshaked negate stage with 2-entry skid buffer and saturating overflow counter
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : slave side of operand-in / result-out valid/ready channels
//   clear_count  : synchronous clear of ow_count, wins over a same-cycle increment
//   ow_count     : count of accepted overflowing operands, saturating
module n4_c2_neg_stage
    import n4_c2_neg_stage_pkg::*;
#(
    parameter int OWCNT_W = OWCNT_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    n4_c2_neg_stage_if.slave    bus,
    input  logic                clear_count,
    output logic [OWCNT_W-1:0]  ow_count
);
    localparam logic [OWCNT_W-1:0] CNT_MAX = '1;
    occ_t            state_q, state_d;
    res_t            main_q, skid_q, res;
    logic [OP_W-1:0] neg_z;
    logic            in_ready_q, in_xfer, out_xfer, load_main, load_skid, from_skid;
    n4_c2_negator u_neg (
        .x3_x0 (bus.x3_x0),
        .z3_z0 (neg_z),
        .ow    ()
    );
    assign res           = {neg_z, bus.x3_x0[OP_W-1] & neg_z[OP_W-1]};
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = state_q != EMPTY;
    assign bus.z3_z0     = main_q.z;
    assign bus.ow        = main_q.ow;
    assign in_xfer       = bus.in_valid & in_ready_q;
    assign out_xfer      = bus.out_valid & bus.out_ready;
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                state_d   = in_xfer ? FULL1 : EMPTY;
                load_main = in_xfer;
            end
            FULL1: begin
                state_d   = (in_xfer && !out_xfer) ? FULL2 : (!in_xfer && out_xfer) ? EMPTY : FULL1;
                load_main = in_xfer && out_xfer;
                load_skid = in_xfer && !out_xfer;
            end
            FULL2: begin
                state_d   = out_xfer ? FULL1 : FULL2;
                from_skid = out_xfer;
            end
            default: state_d = EMPTY;
        endcase
    end
    // in_ready is registered from the next occupancy so it never depends on out_ready combinationally
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            ow_count   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= state_d != FULL2;
            if (load_main)
                main_q <= res;
            else if (from_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= res;
            ow_count   <= clear_count ? '0 :
                          (in_xfer && res.ow && ow_count != CNT_MAX) ? ow_count + OWCNT_W'(1) : ow_count;
        end
    end
endmodule

// File: doc/n4_c2_neg_stage.md
Name: n4_c2_neg_stage

Overview:
Registered, handshaked wrapper around the 4-digit two's-complement negator. It accepts a stream of 4-bit operands on a valid/ready handshake and returns the negated value with an overflow flag on a second valid/ready handshake. It sits between an operand producer (register file or ALU input mux) and any consumer of negated operands, such as a subtractor front end. A 2-entry skid buffer decouples backpressure so that in_ready is a pure register output. A saturating counter tallies overflow events.

Parameters:
OWCNT_W, 4, width of the saturating overflow-event counter (legal range 2..16)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
x3_x0  input  4  operand, two's complement
in_valid  input  1  operand valid
in_ready  output  1  stage can accept an operand this cycle
z3_z0  output  4  negated operand
ow  output  1  overflow flag associated with z3_z0
out_valid  output  1  z3_z0/ow valid
out_ready  input  1  consumer accepts this cycle
clear_count  input  1  synchronous clear of ow_count
ow_count  output  OWCNT_W  number of accepted overflowing operands, saturating

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-high.
- Reset values: in_ready=0, out_valid=0, z3_z0=0000, ow=0, ow_count=0, both buffer entries empty. In the first cycle after reset deasserts, in_ready rises to 1.
- Arithmetic: z = (~x + 1) mod 16, computed by the instantiated negator.
- Overflow rule: ow = x3_x0[3] & z3_z0[3]. It is 1 only for x=1000 (-8 has no positive image). For x=0000, ow=0. The negator's own overflow output is left unconnected.
- Transfer rules: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Latency: 1 cycle. An operand accepted at edge k is presented with out_valid=1 after edge k.
- Throughput: 1 operand per cycle while out_ready=1.
- Main register: holds the presented result. out_valid = main full.
- Skid register: captures the result if an input transfer happens while main is full and no output transfer occurs.
- in_ready = ~skid_full. It is registered, never combinationally dependent on out_ready.
- Result is stored post-negation: the {z, ow} pair is computed from x3_x0 in the accepting cycle.

State machine (buffer occupancy):
- EMPTY: input transfer -> FULL1.
- FULL1, no input and no output transfer: stay FULL1.
- FULL1, output transfer only: -> EMPTY.
- FULL1, both input and output transfer: stay FULL1; main loads the new result.
- FULL1, input transfer only: -> FULL2; the new result goes to skid.
- FULL2 (in_ready=0): output transfer -> FULL1; skid moves to main. Otherwise stay FULL2.

Ordering, counter and boundary conditions:
- Ordering: strictly FIFO. No drop, no duplication.
- z3_z0/ow must stay stable while out_valid=1 and out_ready=0.
- ow_count increments on each input transfer with computed ow=1. It saturates at 2^OWCNT_W-1.
- clear_count has priority over the increment: same-cycle clear and increment yields 0.
- Reset mid-operation empties both entries immediately and discards buffered data; ow_count is cleared.
- Input values while in_valid=0 are ignored.

Decomposition:
- Shared package/header: OWCNT_W default, operand width 4, buffer occupancy state encodings (EMPTY, FULL1, FULL2).
- One sub-module: n4_c2_negator, the existing 4-digit negator, instantiated combinationally on x3_x0.
- Skid buffer and counter stay inline; a separate module is not warranted.

Test Plan:
1. Reset held then released; x=0011, in_valid pulse, out_ready=1 -> next cycle out_valid=1, z=1101, ow=0, ow_count=0.
2. Stream 1000, 0000, 0111, 1111 back-to-back with out_ready=1 -> outputs 1000/ow1, 0000/ow0, 1001/ow0, 0001/ow0 on consecutive cycles; ow_count=1.
3. out_ready=0 while sending 0001, 0010 -> in_ready drops to 0 after the second acceptance. z holds 1111 stably. Raising out_ready yields 1111 then 1110, and in_ready returns to 1.
4. Send 1000 seventeen times with OWCNT_W=4 -> ow_count stops at 15. Assert clear_count with a same-cycle 1000 acceptance -> ow_count=0.
5. Fill both entries, then assert reset asynchronously mid-cycle -> out_valid, in_ready, ow_count go to 0 immediately. After release, no stale data is ever presented.
6. Randomized in_valid/out_ready for 1000 cycles against a FIFO scoreboard (z=-x mod 16, ow=(x==1000)) -> zero mismatches, no loss or reordering.
